// File: rtl/spi_track_loader_pkg.sv
// Shared types for the SPI track loader: track word layout, loader FSM states and checksum width.
package hdr_pkg;

    localparam int CKSUM_W = 8;

    typedef struct packed {
        logic [15:0] period;
        logic [7:0]  amplitude;
    } track_word_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } loader_state_t;

endpackage

// File: rtl/spi_track_loader_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a history flop that yields
// single-cycle rise/fall pulses aligned with the synchronised level.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_track_loader.sv
// SPI slave that deserialises a frame of track words and double-buffers it for the tone generators.
// Optional checksum byte after the track words is enabled by defining SPI_FRAME_CHECK_EN.
module spi_track_loader
    import hdr_pkg::*;
#(
    parameter int NUM_INPUTS  = 2,
    parameter int PACKET_SIZE = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cs,
    input  logic                              sck,
    input  logic                              sdi,
    output logic [NUM_INPUTS*PACKET_SIZE-1:0] track_data,
    output logic                              track_update,
    output logic                              frame_err,
    output logic                              busy,
    output logic [15:0]                       frame_cnt
);

    localparam int DATA_BITS = NUM_INPUTS * PACKET_SIZE;
`ifdef SPI_FRAME_CHECK_EN
    localparam int FRAME_BITS = DATA_BITS + CKSUM_W;
`else
    localparam int FRAME_BITS = DATA_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

`ifdef SPI_FRAME_CHECK_EN
    function automatic logic frame_sum_ok(input logic [FRAME_BITS-1:0] f);
        logic [CKSUM_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < DATA_BITS / 8; i++) begin
            sum = sum + f[CKSUM_W + i*8 +: 8];
        end
        return sum == f[CKSUM_W-1:0];
    endfunction
`endif

    logic cs_rise, cs_fall, sck_rise, sck_fall;
    logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
    logic sdi_s;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .din   (cs),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk   (clk),
        .reset (reset),
        .din   (sck),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // sdi is only ever sampled on sck rise, so its level at the same stage depth is enough
    assign sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
    assign sdi_s      = sdi_sync_q[SYNC_STAGES-1];

    loader_state_t          state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]  shadow_q, shadow_d;
    logic [DATA_BITS-1:0]   track_data_q, track_data_d;
    logic                   track_update_q, track_update_d;
    logic                   frame_err_q, frame_err_d;
    logic                   busy_q, busy_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;
    logic                   pending_q, pending_d;
    logic                   frame_ok;

`ifdef SPI_FRAME_CHECK_EN
    assign frame_ok = (bit_cnt_q == CNT_FULL) && frame_sum_ok(shadow_q);
`else
    assign frame_ok = (bit_cnt_q == CNT_FULL);
`endif

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        shadow_d       = shadow_q;
        track_data_d   = track_data_q;
        track_update_d = 1'b0;
        frame_err_d    = 1'b0;
        frame_cnt_d    = frame_cnt_q;
        pending_d      = pending_q;
        case (state_q)
            IDLE: begin
                if (cs_rise || pending_q) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    shadow_d  = '0;
                    pending_d = 1'b0;
                end
            end
            SHIFT: begin
                // a coincident sck edge is dropped so the frame length is decided by cs alone
                if (cs_fall) begin
                    state_d = CHECK;
                end else if (sck_rise) begin
                    if (bit_cnt_q < CNT_FULL) begin
                        shadow_d = {shadow_q[FRAME_BITS-2:0], sdi_s};
                    end
                    if (bit_cnt_q != CNT_OVER) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (cs_rise) begin
                    pending_d = 1'b1;
                end
                if (frame_ok) begin
                    track_data_d   = shadow_q[FRAME_BITS-1 -: DATA_BITS];
                    track_update_d = 1'b1;
                    frame_cnt_d    = frame_cnt_q + 16'd1;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            shadow_q       <= '0;
            track_data_q   <= '0;
            track_update_q <= 1'b0;
            frame_err_q    <= 1'b0;
            busy_q         <= 1'b0;
            frame_cnt_q    <= '0;
            pending_q      <= 1'b0;
            sdi_sync_q     <= '0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            shadow_q       <= shadow_d;
            track_data_q   <= track_data_d;
            track_update_q <= track_update_d;
            frame_err_q    <= frame_err_d;
            busy_q         <= busy_d;
            frame_cnt_q    <= frame_cnt_d;
            pending_q      <= pending_d;
            sdi_sync_q     <= sdi_sync_d;
        end
    end

    assign track_data   = track_data_q;
    assign track_update = track_update_q;
    assign frame_err    = frame_err_q;
    assign busy         = busy_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
